// File: rtl/shade_light_scheduler_pkg.sv
// Shared types and constants for the shade light scheduler.
package shade_light_scheduler_pkg;

  localparam int NORM_WIDTH = 16;
  localparam int NORM_FRAC  = 14;
  localparam int ONE_FIXED  = 1 << NORM_FRAC;

  // Element 0 = x, 1 = y, 2 = z; each element is a signed fixed-point value.
  typedef logic [2:0][NORM_WIDTH-1:0] vec3_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sched_state_e;

  // Clamp a positive intensity sum to 1.0.
  function automatic logic [NORM_WIDTH-1:0] sat_one(input int unsigned sum);
    if (sum > int'(ONE_FIXED)) return NORM_WIDTH'(ONE_FIXED);
    return NORM_WIDTH'(sum);
  endfunction

endpackage

// File: rtl/shade_light_scheduler_if.sv
// Triangle-in / shade-out handshake bundle of the shade light scheduler.
interface shade_light_scheduler_if;
  import shade_light_scheduler_pkg::*;

  vec3_t                 tri_norm_in;
  logic                  tri_valid_in;
  logic                  tri_ready_out;
  logic [NORM_WIDTH-1:0] shade_out;
  logic                  culled_out;
  logic                  shade_valid_out;
  logic                  shade_ready_in;

  modport slave (
    input  tri_norm_in, tri_valid_in, shade_ready_in,
    output tri_ready_out, shade_out, culled_out, shade_valid_out
  );

  modport master (
    output tri_norm_in, tri_valid_in, shade_ready_in,
    input  tri_ready_out, shade_out, culled_out, shade_valid_out
  );

endinterface

// File: rtl/shade_light_scheduler_tag.sv
// Tag shift pipe that tracks requests in flight through the shared dot unit.
module shade_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic push_valid_in,
  input  logic push_cam_in,
  output logic out_valid_out,
  output logic out_cam_out,
  output logic busy_out
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] cam_q, cam_d;

  // Shift every tag one stage toward the output, new tag enters stage 0.
  always_comb begin
    valid_d    = '0;
    cam_d      = '0;
    valid_d[0] = push_valid_in;
    cam_d[0]   = push_cam_in;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      cam_d[i]   = cam_q[i-1];
    end
  end

  // Tag registers; reset drops every in-flight tag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      cam_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cam_q   <= cam_d;
    end
  end

  assign out_valid_out = valid_q[DEPTH-1];
  assign out_cam_out   = cam_q[DEPTH-1];
  assign busy_out      = |valid_q;

endmodule

// File: rtl/shade_light_scheduler.sv
// Time-multiplexes one shared light_intensity unit over the light table for
// each triangle normal, sums lit intensities plus ambient, emits one shade.
module shade_light_scheduler
  import shade_light_scheduler_pkg::*;
#(
  parameter  int N_LIGHTS = 4,
  parameter  int DOT_LAT  = 4,
  parameter  int AMBIENT  = 1638,
  localparam int LIGHT_W  = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1,
  // One spare bit so out-of-range table writes are visible and can be dropped.
  localparam int IDX_W    = LIGHT_W + 1,
  localparam int ACC_W    = NORM_WIDTH + $clog2(N_LIGHTS) + 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  shade_light_scheduler_if.slave  bus,
  input  logic                    cfg_we_in,
  input  logic [IDX_W-1:0]        cfg_idx_in,
  input  vec3_t                   cfg_norm_in,
  output vec3_t                   dot_tri_norm_out,
  output vec3_t                   dot_light_norm_out,
  input  logic [NORM_WIDTH-1:0]   dot_intensity_in,
  input  logic                    dot_lit_in
);

  localparam logic [IDX_W-1:0]   N_IDX    = IDX_W'(N_LIGHTS);
  localparam logic [LIGHT_W-1:0] LAST_IDX = LIGHT_W'(N_LIGHTS - 1);

  sched_state_e         state_q, state_d;
  logic [LIGHT_W-1:0]   idx_q, idx_d;
  vec3_t                norm_q, norm_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 culled_q, culled_d;
  vec3_t                table_q [N_LIGHTS];
  vec3_t                table_d [N_LIGHTS];

  logic                 push_valid, push_cam;
  logic                 tag_valid, tag_cam, tag_busy;
  logic [ACC_W-1:0]     shade_sum;

  shade_tag_pipe #(.DEPTH(DOT_LAT)) u_tag_pipe (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .push_valid_in (push_valid),
    .push_cam_in   (push_cam),
    .out_valid_out (tag_valid),
    .out_cam_out   (tag_cam),
    .busy_out      (tag_busy)
  );

  // Next state, issue control and result accumulation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    norm_d     = norm_q;
    acc_d      = acc_q;
    culled_d   = culled_q;
    push_valid = 1'b0;
    push_cam   = 1'b0;

    if (tag_valid) begin
      if (dot_lit_in) acc_d = acc_q + ACC_W'(dot_intensity_in);
      if (tag_cam)    culled_d = !dot_lit_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.tri_valid_in) begin
          state_d  = ST_ISSUE;
          norm_d   = bus.tri_norm_in;
          idx_d    = '0;
          acc_d    = '0;
          culled_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        push_valid = 1'b1;
        push_cam   = (idx_q == '0);
        if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_DRAIN: begin
        if (!tag_busy) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.shade_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Light table update; the issue path reads the registered copy, so a
  // same-cycle write to the index being issued is seen only next time.
  always_comb begin
    table_d = table_q;
    if (cfg_we_in && (cfg_idx_in < N_IDX)) table_d[cfg_idx_in[LIGHT_W-1:0]] = cfg_norm_in;
  end

  // State, datapath and light table registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      norm_q   <= '0;
      acc_q    <= '0;
      culled_q <= 1'b0;
      table_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      norm_q   <= norm_d;
      acc_q    <= acc_d;
      culled_q <= culled_d;
      table_q  <= table_d;
    end
  end

  assign shade_sum           = acc_q + ACC_W'(AMBIENT);
  assign bus.tri_ready_out   = (state_q == ST_IDLE);
  assign bus.shade_valid_out = (state_q == ST_OUT);
  assign bus.culled_out      = (state_q == ST_OUT) && culled_q;
  assign bus.shade_out       = ((state_q == ST_OUT) && !culled_q) ? sat_one(32'(shade_sum)) : '0;
  assign dot_tri_norm_out    = (state_q == ST_ISSUE) ? norm_q : '0;
  assign dot_light_norm_out  = (state_q == ST_ISSUE) ? table_q[idx_q] : '0;

endmodule

// File: tb/tb_shade_light_scheduler.sv
// Directed bench for shade_light_scheduler with a behavioural light_intensity unit.
module tb_shade_light_scheduler;
  import shade_light_scheduler_pkg::*;

  localparam int N_LIGHTS = 4;
  localparam int DOT_LAT  = 4;
  localparam int ONE      = 16384;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in = 1'b0;
  logic                  cfg_we_in = 1'b0;
  logic [2:0]            cfg_idx_in = '0;
  vec3_t                 cfg_norm_in = '0;
  vec3_t                 dot_tri_norm_out, dot_light_norm_out;
  logic [NORM_WIDTH-1:0] dot_intensity_in;
  logic                  dot_lit_in;

  int n_checks = 0;
  int n_pass   = 0;

  shade_light_scheduler_if bus_if ();

  shade_light_scheduler #(.N_LIGHTS(N_LIGHTS), .DOT_LAT(DOT_LAT), .AMBIENT(1638)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .bus                (bus_if),
    .cfg_we_in          (cfg_we_in),
    .cfg_idx_in         (cfg_idx_in),
    .cfg_norm_in        (cfg_norm_in),
    .dot_tri_norm_out   (dot_tri_norm_out),
    .dot_light_norm_out (dot_light_norm_out),
    .dot_intensity_in   (dot_intensity_in),
    .dot_lit_in         (dot_lit_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec3_t mk(input int x, input int y, input int z);
    vec3_t v;
    v[0] = 16'(x);
    v[1] = 16'(y);
    v[2] = 16'(z);
    return v;
  endfunction

  function automatic int dot3(input vec3_t a, input vec3_t b);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      int ai, bi;
      ai = int'($signed(a[i]));
      bi = int'($signed(b[i]));
      s += ai * bi;
    end
    return s >>> NORM_FRAC;
  endfunction

  // Light_intensity stand-in: DOT_LAT registers, lit when the dot is negative.
  int m_res [DOT_LAT];
  always @(posedge clk_in) begin
    m_res[0] <= dot3(dot_tri_norm_out, dot_light_norm_out);
    for (int i = 1; i < DOT_LAT; i++) m_res[i] <= m_res[i-1];
  end
  assign dot_lit_in       = (m_res[DOT_LAT-1] < 0);
  assign dot_intensity_in = NORM_WIDTH'(dot_lit_in ? -m_res[DOT_LAT-1] : m_res[DOT_LAT-1]);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cfg_write(input int idx, input vec3_t v);
    cfg_we_in   = 1'b1;
    cfg_idx_in  = 3'(idx);
    cfg_norm_in = v;
    @(posedge clk_in); #1;
    cfg_we_in   = 1'b0;
  endtask

  // Present a normal and return just after the accepting edge.
  task automatic start_tri(input vec3_t v);
    bus_if.tri_norm_in  = v;
    bus_if.tri_valid_in = 1'b1;
    @(posedge clk_in); #1;
    bus_if.tri_valid_in = 1'b0;
    check_val("busy_not_ready", 64'(bus_if.tri_ready_out), 64'(0));
  endtask

  task automatic wait_result(input int n0, input int exp_shade, input bit exp_cull);
    int n;
    n = n0;
    while (!bus_if.shade_valid_out && n < 40) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_val("latency", 64'(n), 64'(N_LIGHTS + DOT_LAT + 1));
    check_val("shade", 64'(bus_if.shade_out), 64'(exp_shade));
    check_val("culled", 64'(bus_if.culled_out), 64'(exp_cull));
  endtask

  task automatic finish_out(input int hold, input int exp_shade, input bit exp_cull);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in); #1;
      check_val("hold_shade", 64'(bus_if.shade_out), 64'(exp_shade));
      check_val("hold_cull", 64'(bus_if.culled_out), 64'(exp_cull));
      check_val("hold_valid", 64'(bus_if.shade_valid_out), 64'(1));
      check_val("hold_ready", 64'(bus_if.tri_ready_out), 64'(0));
    end
    bus_if.shade_ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus_if.shade_ready_in = 1'b0;
    check_val("idle_ready", 64'(bus_if.tri_ready_out), 64'(1));
    check_val("idle_valid", 64'(bus_if.shade_valid_out), 64'(0));
  endtask

  initial begin
    bus_if.tri_norm_in    = '0;
    bus_if.tri_valid_in   = 1'b0;
    bus_if.shade_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_val("rst_ready", 64'(bus_if.tri_ready_out), 64'(1));
    check_val("rst_valid", 64'(bus_if.shade_valid_out), 64'(0));
    check_val("rst_shade", 64'(bus_if.shade_out), 64'(0));
    check_val("rst_cull", 64'(bus_if.culled_out), 64'(0));
    check_val("rst_dot_tri", 64'(dot_tri_norm_out), 64'(0));
    check_val("rst_dot_light", 64'(dot_light_norm_out), 64'(0));
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Camera facing the triangle: 1.0 + ambient saturates to 1.0.
    cfg_write(0, mk(0, 0, -ONE));
    start_tri(mk(0, 0, ONE));
    wait_result(0, ONE, 1'b0);
    finish_out(0, ONE, 1'b0);

    // Back-facing triangle is culled.
    start_tri(mk(0, 0, -ONE));
    wait_result(0, 0, 1'b1);
    finish_out(2, 0, 1'b1);

    // Two lit lights plus ambient: 4096 + 2048 + 1638, held for 10 cycles.
    cfg_write(1, mk(0, 0, -8192));
    start_tri(mk(0, 0, 4096));
    wait_result(0, 7782, 1'b0);
    finish_out(10, 7782, 1'b0);

    // Rewrite light 1 while it is being issued: the old direction goes out.
    start_tri(mk(0, 0, 4096));
    @(posedge clk_in); #1;
    cfg_we_in   = 1'b1;
    cfg_idx_in  = 3'd1;
    cfg_norm_in = mk(0, 0, -ONE);
    check_val("same_cycle_old", 64'(dot_light_norm_out), 64'(mk(0, 0, -8192)));
    @(posedge clk_in); #1;
    cfg_we_in = 1'b0;
    wait_result(2, 7782, 1'b0);
    finish_out(0, 7782, 1'b0);

    // Out-of-range index must not touch the table; light 1 is now 1.0.
    cfg_write(5, mk(0, 0, -4096));
    start_tri(mk(0, 0, 4096));
    wait_result(0, 9830, 1'b0);
    finish_out(0, 9830, 1'b0);

    // Reset while draining, then a clean triangle.
    start_tri(mk(0, 0, ONE));
    repeat (6) @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    check_val("mid_rst_ready", 64'(bus_if.tri_ready_out), 64'(1));
    check_val("mid_rst_valid", 64'(bus_if.shade_valid_out), 64'(0));
    check_val("mid_rst_shade", 64'(bus_if.shade_out), 64'(0));
    check_val("mid_rst_dot", 64'(dot_tri_norm_out), 64'(0));
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    cfg_write(0, mk(0, 0, -ONE));
    cfg_write(1, mk(0, 0, -ONE));
    start_tri(mk(0, 0, 4096));
    wait_result(0, 9830, 1'b0);
    finish_out(1, 9830, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
